mult_ctrl: RTL and testbench
============================

# mult_ctrl

Sequencing controller for the shared pipelined 32x32 signed array multiplier (MULT) in the CPU execute stage. It accepts MULT/MULTU requests from the decoder and holds operands stable for the multiplier's fixed latency. It corrects the signed product for unsigned operations, owns the architectural HI/LO registers (including MTHI/MTLO) and raises a busy interlock so the pipeline stalls MFHI/MFLO and back-to-back multiplies.

## Interface
- WIDTH, 32: operand width; the product is 2*WIDTH.
- LAT, 2: multiplier latency in clock edges, from a `mul_a`/`mul_b` change to a valid `mul_z`.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset. Shared with the multiplier.
- start  in  1  request pulse. Sampled only when `busy`=0.
- is_signed  in  1  1 selects MULT, 0 selects MULTU. Sampled with `start`.
- op_a, op_b  in  WIDTH  operands. Sampled with `start`.
- mthi, mtlo  in  1  write HI/LO directly from `wdata`.
- wdata  in  WIDTH  data for MTHI/MTLO.
- mul_a, mul_b  out  WIDTH  registered operands driven to the multiplier.
- mul_z  in  2*WIDTH  multiplier product (signed interpretation).
- busy  out  1  operation in flight. The pipeline stalls MFHI/MFLO/MULT*.
- done  out  1  one-cycle pulse: HI/LO hold the new result.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- States: IDLE, RUN, DONE. A counter `cnt` (width clog2(LAT+1)) is active only in RUN.
- IDLE/DONE, `start`=1:
  - latch op_a→mul_a, op_b→mul_b and is_signed→sgn_q;
  - set cnt=0 and go to RUN.
- RUN: cnt increments each edge. When cnt==LAT, capture `mul_z`, apply the correction, write HI/LO, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE unless a new `start` arrives.
- Unsigned correction when sgn_q=0, computed from the latched operands:
  - hi = mul_z[63:32] + (mul_a[31] ? mul_b : 0) + (mul_b[31] ? mul_a : 0), mod 2^WIDTH;
  - lo = mul_z[31:0], unchanged.
- Signed (sgn_q=1): hi/lo = mul_z, unmodified.
- mul_a/mul_b stay constant from the accept edge until the writeback edge. They are never changed in RUN.
- `start` while `busy`=1 is ignored and has no side effect. The CPU must stall instead.
- MTHI/MTLO in IDLE or DONE: write at the next edge.
- MTHI/MTLO while busy: cancel the in-flight operation. Go to IDLE, drop the result, apply the write, and suppress `done`.
- MTHI/MTLO together with `start` in IDLE/DONE: both take effect. The move writes immediately; the multiply result overwrites HI and LO later.
- Reset, including mid-RUN: state=IDLE, cnt=0, hi=lo=0, mul_a=mul_b=0, sgn_q=0, busy=0, done=0. Any in-flight result is discarded.

## Timing
- The `start` accept edge is E0.
- mul_a/mul_b are valid after E0.
- The multiplier produces its product after edge E0+LAT.
- Controller writeback of hi/lo happens at edge E0+LAT+1.
- `busy`=1 during the LAT+1 cycles after E0 (3 cycles at LAT=2).
- `done`=1 in the cycle following writeback. busy=0 in that cycle.
- Issue rate: a new `start` is accepted in the DONE cycle, giving one multiply every LAT+2 cycles.
- busy is a registered output, derived from state==RUN. It has no combinational path from `start`.
- done, hi and lo are registered.

## Structure
- Shared package `mul_pkg`:
  - state enum {IDLE, RUN, DONE};
  - localparams WIDTH=32 and LAT=2, so the multiplier and controller stay consistent.
- No sub-module. The correction adder stays inline. The multiplier is instantiated one level up, in the execute stage, next to `mult_ctrl`.
- Verification bench instantiates mult_ctrl plus the real multiplier.

## Test plan
- Reset, then signed MULT 0xFFFFFFFF × 0x00000002 → busy for 3 cycles, then done pulse with hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Unsigned MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE. Then MULTU 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000.
- `start` held high for 8 cycles with differing operands → exactly 2 accepts, one per LAT+2 = 4 cycles. mul_a/mul_b are never changed while busy.
- MTHI 0x12345678 one cycle after accepting MULT 3×4 → no done, hi=0x12345678, lo keeps its prior value, state IDLE.
- Reset asserted in the second RUN cycle of 7×9 → hi=lo=0, busy=0, done never pulses, and the next MULT 7×9 yields lo=63.
- MTLO 0xAAAA plus `start` MULT 2×3 in the same IDLE cycle → lo=0xAAAA the next cycle, then lo=6 and hi=0 at done.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the execute-stage multiplier and its controller.
package mul_pkg;
  localparam int WIDTH = 32;
  localparam int LAT   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;
endpackage

// File: rtl/mult_ctrl.sv
// MULT/MULTU sequencer: holds operands for the pipelined signed multiplier,
// fixes up the signed product for MULTU and owns HI/LO, including MTHI/MTLO.
module mult_ctrl
  import mul_pkg::*;
#(
  parameter int W = WIDTH,
  parameter int L = LAT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           is_signed,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic           mthi,
  input  logic           mtlo,
  input  logic [W-1:0]   wdata,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_z,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo
);
  localparam int CW = $clog2(L + 1);

  mul_state_e    state;
  logic [CW-1:0] cnt;
  logic          sgn_q;
  logic [W-1:0]  hi_fix;

  // Signed-to-unsigned fixup: a negative-looking operand contributed
  // -2^W * other, so add the other operand back into the high half.
  always_comb begin
    hi_fix = mul_z[2*W-1:W];
    if (!sgn_q) begin
      hi_fix = mul_z[2*W-1:W]
             + (mul_a[W-1] ? mul_b : '0)
             + (mul_b[W-1] ? mul_a : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sgn_q <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            mul_a <= op_a;
            mul_b <= op_b;
            sgn_q <= is_signed;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (mthi || mtlo) begin
            // A move to HI/LO wins over the in-flight multiply.
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CW'(L)) begin
            hi    <= hi_fix;
            lo    <= mul_z[W-1:0];
            cnt   <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a two-stage signed multiplier model alongside it.
module tb_mult_ctrl;
  import mul_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, is_signed, mthi, mtlo;
  logic [WIDTH-1:0]  op_a, op_b, wdata;
  logic [WIDTH-1:0]  mul_a, mul_b, hi, lo;
  logic [2*WIDTH-1:0] mul_z;
  logic              busy, done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Stand-in for the execute-stage signed multiplier: LAT=2 register stages.
  logic signed [2*WIDTH-1:0] ea, eb, p1;
  assign ea = {{WIDTH{mul_a[WIDTH-1]}}, mul_a};
  assign eb = {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
  always_ff @(posedge clk) begin
    if (reset) begin
      p1    <= '0;
      mul_z <= '0;
    end else begin
      p1    <= ea * eb;
      mul_z <= p1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one multiply, count busy cycles until done, then check HI/LO.
  task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    int nb;
    logic seen;
    @(negedge clk);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    nb = 0; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) nb++;
      @(negedge clk);
    end
    chk({tag, " done"}, 64'(seen), 64'd1);
    chk({tag, " busy_cycles"}, 64'(nb), 64'd3);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(ehi));
    chk({tag, " lo"}, 64'(lo), 64'(elo));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) hits++;
    end
    chk(tag, 64'(hits), 64'd0);
  endtask

  initial begin
    int accepts, moved;
    logic prev_busy;
    logic [31:0] held_a, held_b;
    logic [31:0] acc_a [2];

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op_a = '0; op_b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst mul_a", 64'(mul_a), 64'd0);

    mul_op(32'hFFFF_FFFF, 32'h2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_neg");
    mul_op(32'hFFFF_FFFF, 32'h2, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, "multu_big");
    mul_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0, "multu_msb");

    // start held for 8 cycles with changing operands
    accepts = 0; moved = 0; prev_busy = 1'b0; held_a = '0; held_b = '0;
    acc_a[0] = '0; acc_a[1] = '0;
    is_signed = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        if (accepts < 2) acc_a[accepts] = mul_a;
        accepts++;
        held_a = mul_a; held_b = mul_b;
      end else if (busy && (mul_a != held_a || mul_b != held_b)) begin
        moved++;
      end
      prev_busy = busy;
      if (i < 8) begin
        start = 1'b1; op_a = 32'(i + 1); op_b = 32'(i + 10);
      end else begin
        start = 1'b0;
      end
    end
    chk("hold accepts", 64'(accepts), 64'd2);
    chk("hold operands_stable", 64'(moved), 64'd0);
    chk("hold first_a", 64'(acc_a[0]), 64'd1);
    chk("hold second_a", 64'(acc_a[1]), 64'd5);
    chk("hold lo", 64'(lo), 64'd70);
    chk("hold hi", 64'(hi), 64'd0);

    // MTHI one cycle after accept cancels the multiply
    @(negedge clk);
    start = 1'b1; is_signed = 1'b1; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("cancel busy_before", 64'(busy), 64'd1);
    mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    chk("cancel hi", 64'(hi), 64'h1234_5678);
    chk("cancel lo", 64'(lo), 64'd70);
    chk("cancel busy", 64'(busy), 64'd0);
    watch_no_done("cancel no_done", 6);
    chk("cancel lo_kept", 64'(lo), 64'd70);

    // reset in the second RUN cycle
    @(negedge clk);
    start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst mul_a", 64'(mul_a), 64'd0);
    watch_no_done("midrst no_done", 6);
    mul_op(32'd7, 32'd9, 1'b1, 32'd0, 32'd63, "after_rst");

    // MTLO and start in the same idle cycle
    @(negedge clk);
    mtlo = 1'b1; wdata = 32'hAAAA; start = 1'b1; is_signed = 1'b1; op_a = 32'd2; op_b = 32'd3;
    @(negedge clk);
    mtlo = 1'b0; start = 1'b0;
    chk("mtlo_start lo_now", 64'(lo), 64'hAAAA);
    chk("mtlo_start busy", 64'(busy), 64'd1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (done) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      chk("mtlo_start done", 64'(seen), 64'd1);
      chk("mtlo_start lo", 64'(lo), 64'd6);
      chk("mtlo_start hi", 64'(hi), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
